// File: rtl/axon_pkg.sv
// Shared types and phase-length helpers for the axon row scheduler.
// Phase lengths are computed in 32-bit arithmetic and narrowed by the caller.
package axon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EJECT = 3'd3,
    ST_SHIFT = 3'd4,
    ST_CLEAR = 3'd5
  } state_t;

  function automatic int unsigned load_len(input int unsigned k, input int unsigned n);
    return k + n - 1;
  endfunction

  function automatic int unsigned drain_len(input int unsigned rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/axon_sched_cnt.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module axon_sched_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/axon_row_sched.sv
// Scheduler for one output-stationary PE row: skewed SRAM reads, accumulate,
// eject, shift-out and clear, one job per accepted start.
module axon_row_sched
  import axon_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int K_W    = 10,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    ifmap_rd_en,
  output logic [K_W-1:0]          ifmap_rd_addr,
  output logic [NUM_PE-1:0]       wgt_rd_en,
  output logic [K_W*NUM_PE-1:0]   wgt_rd_addr,
  output logic [NUM_PE-1:0]       ifmap_in_sel,
  output logic [NUM_PE-1:0]       out_eject,
  output logic                    psum_clr,
  output logic                    out_valid,
  output logic [$clog2(NUM_PE)-1:0] out_idx
);

  localparam int IW       = $clog2(NUM_PE);
  localparam int CW       = K_W + IW + 1;
  localparam int DRAIN_M1 = int'(drain_len(RD_LAT)) - 1;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q;
  logic           err_q, abort_q;
  logic           accept, zero_job;

  logic           ph_load, ph_zero;
  logic [CW-1:0]  ph_val, ph_cnt;
  logic           rd_load, rd_zero;
  logic [K_W-1:0] rd_val, rd_rem;

  logic           in_load;
  logic [CW-1:0]  ld_m1, c_idx, k_ext;

  // ph_cnt times every phase; in SHIFT it doubles as the output index
  axon_sched_cnt #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (1'b1),
    .cnt      (ph_cnt),
    .zero     (ph_zero)
  );

  axon_sched_cnt #(.W(K_W)) u_rd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rd_load),
    .load_val (rd_val),
    .dec      (in_load),
    .cnt      (rd_rem),
    .zero     (rd_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) k_q <= k_len;
      err_q   <= zero_job;
      abort_q <= abort && (state_q != ST_IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_load  = 1'b0;
    ph_val   = '0;
    rd_load  = 1'b0;
    rd_val   = '0;
    accept   = 1'b0;
    zero_job = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              accept  = 1'b1;
              state_d = ST_LOAD;
              ph_load = 1'b1;
              ph_val  = CW'(load_len(32'(k_len), NUM_PE) - 1);
              rd_load = 1'b1;
              rd_val  = k_len;
            end else begin
              zero_job = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (ph_zero) begin
            state_d = ST_DRAIN;
            ph_load = 1'b1;
            ph_val  = CW'(DRAIN_M1);
          end
        end
        ST_DRAIN: begin
          if (ph_zero) begin
            state_d = ST_EJECT;
            ph_load = 1'b1;
          end
        end
        ST_EJECT: begin
          state_d = ST_SHIFT;
          ph_load = 1'b1;
          ph_val  = CW'(NUM_PE - 1);
        end
        ST_SHIFT: begin
          if (ph_zero) begin
            state_d = ST_CLEAR;
            ph_load = 1'b1;
          end
        end
        ST_CLEAR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign in_load = (state_q == ST_LOAD);
  assign ld_m1   = CW'(load_len(32'(k_q), NUM_PE) - 1);
  assign c_idx   = ld_m1 - ph_cnt;
  assign k_ext   = CW'(k_q);

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_CLEAR) || err_q;
  assign err       = err_q;
  assign psum_clr  = (state_q == ST_CLEAR) || abort_q;
  assign out_eject = {NUM_PE{state_q == ST_EJECT}};
  assign out_valid = (state_q == ST_SHIFT);
  assign out_idx   = out_valid ? IW'(ph_cnt) : '0;

  assign ifmap_in_sel  = NUM_PE'(1);
  assign ifmap_rd_en   = in_load && !rd_zero;
  assign ifmap_rd_addr = ifmap_rd_en ? (k_q - rd_rem) : '0;

  // Bank i runs i cycles behind PE0 to meet the ifmap as it hops down the chain
  for (genvar i = 0; i < NUM_PE; i++) begin : g_wgt
    localparam logic [CW-1:0] IDX = CW'(i);
    logic hit;
    assign hit                       = in_load && (c_idx >= IDX) && (c_idx < IDX + k_ext);
    assign wgt_rd_en[i]              = hit;
    assign wgt_rd_addr[i*K_W +: K_W] = hit ? K_W'(c_idx - IDX) : '0;
  end

endmodule

// File: tb/tb_axon_row_sched.sv
// Directed bench for axon_row_sched (4 PEs, RD_LAT 1) with a small PE-row model
// fed by the scheduler's strobes; ifmap word a holds a+1, every weight is 2.
module tb_axon_row_sched;

  localparam int NP = 4;
  localparam int KW = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort;
  logic [KW-1:0]     k_len;
  logic              busy, done, err, ifmap_rd_en, psum_clr, out_valid;
  logic [KW-1:0]     ifmap_rd_addr;
  logic [NP-1:0]     wgt_rd_en, ifmap_in_sel, out_eject;
  logic [KW*NP-1:0]  wgt_rd_addr;
  logic [1:0]        out_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;

  typedef struct {
    logic [KW-1:0] k;
    int lat;
    int err;
    int busy;
    int reads;
    int eject;
    int valid;
    int result;
  } vec_t;

  vec_t vecs[5];

  axon_row_sched #(.NUM_PE(NP), .K_W(KW), .RD_LAT(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .k_len         (k_len),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .ifmap_rd_en   (ifmap_rd_en),
    .ifmap_rd_addr (ifmap_rd_addr),
    .wgt_rd_en     (wgt_rd_en),
    .wgt_rd_addr   (wgt_rd_addr),
    .ifmap_in_sel  (ifmap_in_sel),
    .out_eject     (out_eject),
    .psum_clr      (psum_clr),
    .out_valid     (out_valid),
    .out_idx       (out_idx)
  );

  always #5 clk = ~clk;

  // PE row model: SRAM stage, PE input regs, accumulate, eject/shift chain
  logic [31:0] sram_q;
  logic [31:0] pe_in[NP], w_reg[NP], w_in[NP], psum[NP], out_reg[NP];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_q <= 32'd0;
      for (int i = 0; i < NP; i++) begin
        pe_in[i] <= 32'd0; w_reg[i] <= 32'd0; w_in[i] <= 32'd0;
        psum[i] <= 32'd0;  out_reg[i] <= 32'd0;
      end
    end else begin
      sram_q   <= ifmap_rd_en ? 32'(ifmap_rd_addr) + 32'd1 : 32'd0;
      pe_in[0] <= ifmap_in_sel[0] ? sram_q : 32'd0;
      for (int i = 1; i < NP; i++) pe_in[i] <= ifmap_in_sel[i] ? 32'd0 : pe_in[i-1];
      for (int i = 0; i < NP; i++) begin
        w_reg[i] <= wgt_rd_en[i] ? 32'd2 : 32'd0;
        w_in[i]  <= w_reg[i];
        psum[i]  <= psum_clr ? 32'd0 : psum[i] + pe_in[i] * w_in[i];
      end
      out_reg[0] <= out_eject[0] ? psum[0] : 32'd0;
      for (int i = 1; i < NP; i++) out_reg[i] <= out_eject[i] ? psum[i] : out_reg[i-1];
    end
  end

  always @(negedge clk) if (done) done_count++;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic a, input logic [KW-1:0] k);
    start = s;
    abort = a;
    k_len = k;
  endtask

  // Launch one job, watch every cycle until done, then compare the tallies
  task automatic run_row(input vec_t v);
    int lat, n_if, n_ej, n_val, bad_ia, bad_wa, bad_ej, bad_idx, bad_res;
    int n_w[NP];
    int err_s, busy_s, busy_after;
    string tag;
    lat = -1; n_if = 0; n_ej = 0; n_val = 0;
    bad_ia = 0; bad_wa = 0; bad_ej = 0; bad_idx = 0; bad_res = 0;
    err_s = -1; busy_s = -1;
    foreach (n_w[i]) n_w[i] = 0;
    tag = $sformatf("k%0d", v.k);
    @(negedge clk); apply_stimulus(1'b1, 1'b0, v.k);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0);
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      if (ifmap_rd_en) begin
        if (int'(ifmap_rd_addr) != n_if) bad_ia++;
        n_if++;
      end
      for (int i = 0; i < NP; i++) begin
        if (wgt_rd_en[i]) begin
          if (int'(wgt_rd_addr[i*KW +: KW]) != n_w[i]) bad_wa++;
          n_w[i]++;
        end
      end
      if (out_eject != '0) begin
        if (out_eject != 4'hF) bad_ej++;
        n_ej++;
      end
      if (out_valid) begin
        if (int'(out_idx) != NP - 1 - n_val) bad_idx++;
        if (int'(out_reg[NP-1]) != v.result) bad_res++;
        n_val++;
      end
      if (done) begin
        lat = cyc; err_s = int'(err); busy_s = int'(busy);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    busy_after = int'(busy);
    check_output({tag, " latency"},        lat,        v.lat);
    check_output({tag, " err"},            err_s,      v.err);
    check_output({tag, " busy at done"},   busy_s,     v.busy);
    check_output({tag, " busy after"},     busy_after, 0);
    check_output({tag, " ifmap reads"},    n_if,       v.reads);
    check_output({tag, " wgt0 reads"},     n_w[0],     v.reads);
    check_output({tag, " wgt3 reads"},     n_w[NP-1],  v.reads);
    check_output({tag, " ifmap addr bad"}, bad_ia,     0);
    check_output({tag, " wgt addr bad"},   bad_wa,     0);
    check_output({tag, " eject cycles"},   n_ej,       v.eject);
    check_output({tag, " eject partial"},  bad_ej,     0);
    check_output({tag, " valid cycles"},   n_val,      v.valid);
    check_output({tag, " out_idx bad"},    bad_idx,    0);
    check_output({tag, " result bad"},     bad_res,    0);
  endtask

  initial begin
    int cyc, d0;
    vec_t big;
    // k, latency (k+12), err, busy@done, reads, ejects, valids, tail result k*(k+1)
    vecs[0] = '{10'd3, 15, 0, 1, 3, 1, 4, 12};
    vecs[1] = '{10'd1, 13, 0, 1, 1, 1, 4, 2};
    vecs[2] = '{10'd5, 17, 0, 1, 5, 1, 4, 30};
    vecs[3] = '{10'd0,  1, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{10'd2, 14, 0, 1, 2, 1, 4, 6};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    check_output("reset busy",          int'(busy),          0);
    check_output("reset done",          int'(done),          0);
    check_output("reset err",           int'(err),           0);
    check_output("reset ifmap_rd_en",   int'(ifmap_rd_en),   0);
    check_output("reset wgt_rd_en",     int'(wgt_rd_en),     0);
    check_output("reset wgt_rd_addr",   int'(wgt_rd_addr),   0);
    check_output("reset ifmap_in_sel",  int'(ifmap_in_sel),  1);
    check_output("reset out_eject",     int'(out_eject),     0);
    check_output("reset psum_clr",      int'(psum_clr),      0);
    check_output("reset out_valid",     int'(out_valid),     0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_row(vecs[i]);

    // start during SHIFT and in the done cycle are dropped; start right after is taken
    d0 = done_count;
    @(negedge clk); apply_stimulus(1'b1, 1'b0, 10'd3);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check_output("T4 shift reached at", cyc, 11);
    apply_stimulus(1'b1, 1'b0, 10'd3);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0); cyc++;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    check_output("T4 first latency", cyc, 15);
    apply_stimulus(1'b1, 1'b0, 10'd2);
    @(negedge clk);
    check_output("T4 start in done cycle ignored", int'(busy), 0);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0);
    check_output("T4 start after done taken", int'(busy), 1);
    cyc = 1;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    check_output("T4 second latency", cyc, 14);
    @(negedge clk);
    check_output("T4 done pulses", done_count - d0, 2);

    // abort in LOAD cycle 2
    d0 = done_count;
    @(negedge clk); apply_stimulus(1'b1, 1'b0, 10'd3);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    check_output("T5 reading before abort", int'(ifmap_rd_en), 1);
    apply_stimulus(1'b0, 1'b1, '0);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0);
    check_output("T5 ifmap_rd_en", int'(ifmap_rd_en), 0);
    check_output("T5 wgt_rd_en",   int'(wgt_rd_en),   0);
    check_output("T5 psum_clr",    int'(psum_clr),    1);
    check_output("T5 busy",        int'(busy),        0);
    @(negedge clk);
    check_output("T5 psum_clr one cycle", int'(psum_clr), 0);
    repeat (25) @(negedge clk);
    check_output("T5 no done", done_count - d0, 0);

    // abort together with start in IDLE
    apply_stimulus(1'b1, 1'b1, 10'd3);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0);
    check_output("abort+start busy",     int'(busy),     0);
    check_output("abort idle psum_clr",  int'(psum_clr), 0);

    // async reset in SHIFT, then the longest job
    @(negedge clk); apply_stimulus(1'b1, 1'b0, 10'd3);
    @(negedge clk); apply_stimulus(1'b0, 1'b0, '0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check_output("T6 in SHIFT", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("T6 out_valid async", int'(out_valid), 0);
    check_output("T6 busy async",      int'(busy),      0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_output("T6 idle after release", int'(busy), 0);
    check_output("T6 no done after release", int'(done), 0);
    big = '{10'd1023, 1035, 0, 1, 1023, 1, 4, 1047552};
    run_row(big);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
